// File: rtl/aq_gemac_miim_ctrl.sv
// Arbiter/sequencer sharing one MIIM master between a host register-access
// port and an autonomous PHY link-status poller.
module aq_gemac_miim_ctrl #(
  parameter logic [31:0] POLL_INTERVAL = 32'd1250000,
  parameter logic [4:0]  POLL_REG      = 5'd1,
  parameter logic [3:0]  LINK_BIT      = 4'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_req_i,
  input  logic        host_write_i,
  input  logic [4:0]  host_phy_address_i,
  input  logic [4:0]  host_reg_address_i,
  input  logic [15:0] host_wdata_i,
  output logic        host_busy_o,
  output logic        host_ack_o,
  output logic [15:0] host_rdata_o,
  input  logic        poll_enable_i,
  input  logic [4:0]  poll_phy_address_i,
  output logic        link_status_o,
  output logic        link_change_o,
  output logic [15:0] poll_rdata_o,
  output logic        miim_request_o,
  output logic        miim_write_o,
  output logic [4:0]  miim_phy_address_o,
  output logic [4:0]  miim_reg_address_o,
  output logic [15:0] miim_wdata_o,
  input  logic [15:0] miim_rdata_i,
  input  logic        miim_busy_i
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned TMO_W = 2;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(3);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT_START, ST_WAIT_DONE, ST_COMPLETE
  } state_e;

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]  poll_cnt_q, poll_cnt_d;
  logic              host_pend_q, host_pend_d;
  logic              poll_pend_q, poll_pend_d;
  logic              last_host_q, last_host_d;
  logic              grant_host_q, grant_host_d;
  logic              timeout_q, timeout_d;
  logic              hwrite_q, hwrite_d;
  logic [4:0]        hphy_q, hphy_d;
  logic [4:0]        hreg_q, hreg_d;
  logic [15:0]       hwdata_q, hwdata_d;
  logic              host_busy_q, host_busy_d;
  logic              host_ack_q, host_ack_d;
  logic [15:0]       host_rdata_q, host_rdata_d;
  logic              link_status_q, link_status_d;
  logic              link_change_q, link_change_d;
  logic [15:0]       poll_rdata_q, poll_rdata_d;
  logic              miim_request_q, miim_request_d;
  logic              miim_write_q, miim_write_d;
  logic [4:0]        miim_phy_q, miim_phy_d;
  logic [4:0]        miim_reg_q, miim_reg_d;
  logic [15:0]       miim_wdata_q, miim_wdata_d;

  logic              accept;
  logic              poll_tc;
  logic              poll_clr;
  logic              pick_host;
  logic [15:0]       rdata_sel;

  // Next-state and output computation
  always_comb begin
    state_d        = state_q;
    tmo_cnt_d      = tmo_cnt_q;
    poll_cnt_d     = poll_cnt_q;
    host_pend_d    = host_pend_q;
    poll_pend_d    = poll_pend_q;
    last_host_d    = last_host_q;
    grant_host_d   = grant_host_q;
    timeout_d      = timeout_q;
    hwrite_d       = hwrite_q;
    hphy_d         = hphy_q;
    hreg_d         = hreg_q;
    hwdata_d       = hwdata_q;
    host_busy_d    = host_busy_q;
    host_ack_d     = 1'b0;
    host_rdata_d   = host_rdata_q;
    link_status_d  = link_status_q;
    link_change_d  = 1'b0;
    poll_rdata_d   = poll_rdata_q;
    miim_request_d = 1'b0;
    miim_write_d   = miim_write_q;
    miim_phy_d     = miim_phy_q;
    miim_reg_d     = miim_reg_q;
    miim_wdata_d   = miim_wdata_q;
    accept         = host_req_i && !host_busy_q;
    poll_tc        = 1'b0;
    poll_clr       = 1'b0;
    pick_host      = 1'b0;
    rdata_sel      = timeout_q ? 16'hFFFF : miim_rdata_i;

    if (accept) begin
      hwrite_d    = host_write_i;
      hphy_d      = host_phy_address_i;
      hreg_d      = host_reg_address_i;
      hwdata_d    = host_wdata_i;
      host_pend_d = 1'b1;
      host_busy_d = 1'b1;
    end
    // Busy stays high through the ack cycle and drops right after it
    if (host_ack_q) host_busy_d = 1'b0;

    if (!poll_enable_i) begin
      poll_cnt_d = '0;
    end else if (poll_cnt_q == POLL_INTERVAL - 32'd1) begin
      poll_cnt_d = '0;
      poll_tc    = 1'b1;
    end else begin
      poll_cnt_d = poll_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (!miim_busy_i && (host_pend_q || poll_pend_q)) begin
          pick_host      = host_pend_q && (!poll_pend_q || !last_host_q);
          grant_host_d   = pick_host;
          last_host_d    = pick_host;
          timeout_d      = 1'b0;
          miim_request_d = 1'b1;
          miim_write_d   = pick_host ? hwrite_q : 1'b0;
          miim_phy_d     = pick_host ? hphy_q   : poll_phy_address_i;
          miim_reg_d     = pick_host ? hreg_q   : POLL_REG;
          miim_wdata_d   = pick_host ? hwdata_q : 16'h0000;
          state_d        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (miim_busy_i) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_COMPLETE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!miim_busy_i) state_d = ST_COMPLETE;
      end
      ST_COMPLETE: begin
        if (grant_host_q) begin
          if (!miim_write_q) host_rdata_d = rdata_sel;
          host_ack_d  = 1'b1;
          host_pend_d = 1'b0;
        end else begin
          poll_rdata_d  = rdata_sel;
          link_status_d = rdata_sel[LINK_BIT];
          link_change_d = rdata_sel[LINK_BIT] != link_status_q;
          poll_clr      = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh expiry wins over the clear from a completing poll
    if (!poll_enable_i)  poll_pend_d = 1'b0;
    else if (poll_tc)    poll_pend_d = 1'b1;
    else if (poll_clr)   poll_pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      tmo_cnt_q      <= '0;
      poll_cnt_q     <= '0;
      host_pend_q    <= 1'b0;
      poll_pend_q    <= 1'b0;
      last_host_q    <= 1'b0;
      grant_host_q   <= 1'b0;
      timeout_q      <= 1'b0;
      hwrite_q       <= 1'b0;
      hphy_q         <= '0;
      hreg_q         <= '0;
      hwdata_q       <= '0;
      host_busy_q    <= 1'b0;
      host_ack_q     <= 1'b0;
      host_rdata_q   <= '0;
      link_status_q  <= 1'b0;
      link_change_q  <= 1'b0;
      poll_rdata_q   <= '0;
      miim_request_q <= 1'b0;
      miim_write_q   <= 1'b0;
      miim_phy_q     <= '0;
      miim_reg_q     <= '0;
      miim_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      tmo_cnt_q      <= tmo_cnt_d;
      poll_cnt_q     <= poll_cnt_d;
      host_pend_q    <= host_pend_d;
      poll_pend_q    <= poll_pend_d;
      last_host_q    <= last_host_d;
      grant_host_q   <= grant_host_d;
      timeout_q      <= timeout_d;
      hwrite_q       <= hwrite_d;
      hphy_q         <= hphy_d;
      hreg_q         <= hreg_d;
      hwdata_q       <= hwdata_d;
      host_busy_q    <= host_busy_d;
      host_ack_q     <= host_ack_d;
      host_rdata_q   <= host_rdata_d;
      link_status_q  <= link_status_d;
      link_change_q  <= link_change_d;
      poll_rdata_q   <= poll_rdata_d;
      miim_request_q <= miim_request_d;
      miim_write_q   <= miim_write_d;
      miim_phy_q     <= miim_phy_d;
      miim_reg_q     <= miim_reg_d;
      miim_wdata_q   <= miim_wdata_d;
    end
  end

  assign host_busy_o        = host_busy_q;
  assign host_ack_o         = host_ack_q;
  assign host_rdata_o       = host_rdata_q;
  assign link_status_o      = link_status_q;
  assign link_change_o      = link_change_q;
  assign poll_rdata_o       = poll_rdata_q;
  assign miim_request_o     = miim_request_q;
  assign miim_write_o       = miim_write_q;
  assign miim_phy_address_o = miim_phy_q;
  assign miim_reg_address_o = miim_reg_q;
  assign miim_wdata_o       = miim_wdata_q;

endmodule

// File: tb/tb_aq_gemac_miim_ctrl.sv
// Directed bench for aq_gemac_miim_ctrl with a behavioural MIIM master model.
module tb_aq_gemac_miim_ctrl;

  localparam logic [4:0] POLL_REG = 5'd1;
  localparam logic [4:0] POLL_PHY = 5'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_req = 1'b0, host_write = 1'b0;
  logic [4:0]  host_phy = '0, host_reg = '0;
  logic [15:0] host_wdata = '0;
  logic        host_busy, host_ack;
  logic [15:0] host_rdata;
  logic        poll_enable = 1'b0;
  logic        link_status, link_change;
  logic [15:0] poll_rdata;
  logic        miim_request, miim_write;
  logic [4:0]  miim_phy, miim_reg;
  logic [15:0] miim_wdata;
  logic [15:0] model_rdata = '0;
  logic        model_busy = 1'b0, model_dead = 1'b0, force_busy = 1'b0;
  logic        miim_busy;
  int          busy_cnt = 0;

  assign miim_busy = model_busy | force_busy;

  aq_gemac_miim_ctrl #(.POLL_INTERVAL(32'd100)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req_i(host_req), .host_write_i(host_write),
    .host_phy_address_i(host_phy), .host_reg_address_i(host_reg),
    .host_wdata_i(host_wdata), .host_busy_o(host_busy), .host_ack_o(host_ack),
    .host_rdata_o(host_rdata), .poll_enable_i(poll_enable),
    .poll_phy_address_i(POLL_PHY), .link_status_o(link_status),
    .link_change_o(link_change), .poll_rdata_o(poll_rdata),
    .miim_request_o(miim_request), .miim_write_o(miim_write),
    .miim_phy_address_o(miim_phy), .miim_reg_address_o(miim_reg),
    .miim_wdata_o(miim_wdata), .miim_rdata_i(model_rdata), .miim_busy_i(miim_busy)
  );

  always #5 clk = ~clk;

  // MIIM master model: busy rises the cycle after a request, lasts 5 cycles
  always @(posedge clk) begin
    if (!rst_n) model_busy <= 1'b0;
    else if (miim_request && !model_dead) begin
      model_busy <= 1'b1;
      busy_cnt   <= 4;
    end else if (model_busy) begin
      if (busy_cnt == 0) model_busy <= 1'b0;
      else busy_cnt <= busy_cnt - 1;
    end
  end

  typedef struct packed {
    logic        wr;
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [15:0] wd;
  } cmd_t;

  cmd_t req_log[$];
  int   cyc = 0, req_cnt = 0, ack_cnt = 0, chg_cnt = 0;
  int   req_cyc = 0, ack_cyc = 0, fall_cyc = 0;
  logic prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_busy <= miim_busy;
    if (prev_busy && !miim_busy) fall_cyc <= cyc;
    if (host_ack) begin ack_cnt <= ack_cnt + 1; ack_cyc <= cyc; end
    if (link_change) chg_cnt <= chg_cnt + 1;
    if (miim_request) begin
      req_cnt <= req_cnt + 1;
      req_cyc <= cyc;
      req_log.push_back({miim_write, miim_phy, miim_reg, miim_wdata});
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  phy;
    logic [4:0]  reg_a;
    logic [15:0] wdata;
    logic [15:0] model_rd;
    logic [15:0] exp_rd;
  } vec_t;

  task automatic host_pulse(input logic wr, input logic [4:0] phy, input logic [4:0] ra,
                            input logic [15:0] wd);
    @(posedge clk); #1;
    host_req = 1'b1; host_write = wr; host_phy = phy; host_reg = ra; host_wdata = wd;
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  task automatic wait_host_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!host_busy) ok = 1;
    end
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic do_host(input vec_t v, input logic dead);
    int a0;
    bit got = 0;
    a0 = ack_cnt;
    model_rdata = v.model_rd;
    @(posedge clk); #1;
    host_req = 1'b1; host_write = v.wr; host_phy = v.phy; host_reg = v.reg_a; host_wdata = v.wdata;
    @(negedge clk);
    check("lat_c0_req", 64'(miim_request), 64'd0);
    @(posedge clk); #1;
    host_req = 1'b0;
    @(negedge clk);
    check("lat_c1_req", 64'(miim_request), 64'd0);
    check("busy_accept", 64'(host_busy), 64'd1);
    @(negedge clk);
    check("lat_c2_req", 64'(miim_request), 64'd1);
    check("miim_fields", 64'({miim_write, miim_phy, miim_reg, miim_wdata}),
          64'({v.wr, v.phy, v.reg_a, v.wdata}));
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (host_ack) got = 1;
    end
    check("ack_seen", 64'(got), 64'd1);
    check("host_rdata", 64'(host_rdata), 64'(v.exp_rd));
    check("busy_at_ack", 64'(host_busy), 64'd1);
    @(negedge clk);
    check("busy_after_ack", 64'({host_busy, host_ack}), 64'd0);
    check("ack_count", 64'(ack_cnt - a0), 64'd1);
    if (dead) check("timeout_lat", 64'(ack_cyc - req_cyc), 64'd6);
    else      check("ack_lat", 64'(ack_cyc - fall_cyc), 64'd2);
  endtask

  task automatic wait_change(input string name, input logic exp_link, input logic [15:0] exp_rd);
    bit got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (link_change) got = 1;
    end
    check(name, 64'(got), 64'd1);
    check({name, "_status"}, 64'(link_status), 64'(exp_link));
    check({name, "_rdata"}, 64'(poll_rdata), 64'(exp_rd));
    @(negedge clk);
    check({name, "_pulse"}, 64'(link_change), 64'd0);
  endtask

  // Both requesters pend while the master looks busy; returns grant order on release
  task automatic tie_round(input string name, input logic host_first);
    int r0, n0;
    bit got = 0;
    @(posedge clk); #1 force_busy = 1'b1;
    model_rdata = 16'h0000;
    host_pulse(1'b0, 5'd9, 5'd3, 16'h0000);
    @(posedge clk); #1 poll_enable = 1'b1;
    r0 = req_cnt;
    repeat (120) @(negedge clk);
    check({name, "_no_grant_busy"}, 64'(req_cnt - r0), 64'd0);
    n0 = req_log.size();
    @(posedge clk); #1 force_busy = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_log.size() >= n0 + 2) got = 1;
    end
    check({name, "_two_grants"}, 64'(got), 64'd1);
    if (got) begin
      check({name, "_first"}, 64'({req_log[n0].phy, req_log[n0].ra}),
            host_first ? 64'({5'd9, 5'd3}) : 64'({POLL_PHY, POLL_REG}));
      check({name, "_second"}, 64'({req_log[n0+1].phy, req_log[n0+1].ra}),
            host_first ? 64'({POLL_PHY, POLL_REG}) : 64'({5'd9, 5'd3}));
    end
    @(posedge clk); #1 poll_enable = 1'b0;
    wait_host_idle({name, "_host_done"});
    repeat (30) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[5];
  vec_t v;
  int   r0, a0, c0;
  bit   got;

  initial begin
    vecs[0] = '{1'b1, 5'd1,  5'd0,  16'h1200, 16'h5555, 16'h0000};
    vecs[1] = '{1'b0, 5'd1,  5'd2,  16'h0000, 16'hBEEF, 16'hBEEF};
    vecs[2] = '{1'b1, 5'd3,  5'd4,  16'hA5A5, 16'h1234, 16'hBEEF};
    vecs[3] = '{1'b0, 5'd31, 5'd31, 16'h0000, 16'h0001, 16'h0001};
    vecs[4] = '{1'b0, 5'd0,  5'd1,  16'h0000, 16'hFFFE, 16'hFFFE};

    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({host_busy, host_ack, host_rdata, link_status, link_change,
          poll_rdata, miim_request, miim_write, miim_phy, miim_reg, miim_wdata}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) do_host(vecs[i], 1'b0);

    // Ignored request while busy: only one transaction results
    r0 = req_cnt;
    model_rdata = 16'h0101;
    host_pulse(1'b0, 5'd5, 5'd5, 16'h0000);
    host_pulse(1'b0, 5'd6, 5'd6, 16'h0000);
    wait_host_idle("busy_drop_idle");
    repeat (20) @(negedge clk);
    check("busy_drop_req_count", 64'(req_cnt - r0), 64'd1);
    check("busy_drop_rdata", 64'(host_rdata), 64'h0101);

    // Poller: link up, link down, then steady with no change
    c0 = chg_cnt;
    model_rdata = 16'h0004;
    @(posedge clk); #1 poll_enable = 1'b1;
    wait_change("link_up", 1'b1, 16'h0004);
    check("poll_cmd", 64'(req_log[req_log.size()-1]), 64'({1'b0, POLL_PHY, POLL_REG, 16'h0000}));
    model_rdata = 16'h0000;
    wait_change("link_down", 1'b0, 16'h0000);
    repeat (250) @(negedge clk);
    check("link_change_count", 64'(chg_cnt - c0), 64'd2);
    @(posedge clk); #1 poll_enable = 1'b0;
    repeat (20) @(negedge clk);
    r0 = req_cnt;
    repeat (150) @(negedge clk);
    check("poll_disabled_quiet", 64'(req_cnt - r0), 64'd0);

    // Round-robin ties
    tie_round("tie1", 1'b1);
    host_pulse(1'b0, 5'd2, 5'd2, 16'h0000);
    wait_host_idle("solo_host_idle");
    repeat (10) @(negedge clk);
    tie_round("tie2", 1'b0);

    // Master never responds
    model_dead = 1'b1;
    v = '{1'b0, 5'd4, 5'd6, 16'h0000, 16'h1357, 16'hFFFF};
    do_host(v, 1'b1);
    model_dead = 1'b0;
    repeat (5) @(negedge clk);

    // Reset during WAIT_DONE
    a0 = ack_cnt;
    model_rdata = 16'h1111;
    host_pulse(1'b0, 5'd2, 5'd5, 16'h0000);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (miim_busy) got = 1;
    end
    check("rst_busy_seen", 64'(got), 64'd1);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("rst_outputs_zero", 64'({host_busy, host_ack, host_rdata, link_status, link_change,
          poll_rdata, miim_request, miim_write, miim_phy, miim_reg, miim_wdata}), 64'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_no_ack", 64'(ack_cnt - a0), 64'd0);
    v = '{1'b0, 5'd2, 5'd5, 16'h0000, 16'h2222, 16'h2222};
    do_host(v, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
